// File: rtl/ns_link_arbiter_pkg.sv
// Shared definitions for the link arbiter: FSM state encodings, grant index
// width and the round-robin pointer advance helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
//
// NS_DATA_SIZE is the default message data width for every arbiter build.
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

package ns_link_arbiter_pkg;

    // Grant index width; covers the largest legal source count (8).
    localparam int RR_W     = 3;
    localparam int NSRC_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for any source request
        ST_SEND = 2'd1,   // o_req high, waiting for sink acknowledge
        ST_ACKD = 2'd2,   // grantee acknowledged, waiting for its req to fall
        ST_DROP = 2'd3    // o_req low, waiting for sink acknowledge to fall
    } arb_state_t;

    // Pointer to the source after idx, wrapping from nsrc-1 back to 0.
    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] idx,
                                                 input int              nsrc);
        if (int'(idx) == nsrc - 1) begin
            rr_next = '0;
        end else begin
            rr_next = idx + RR_W'(1);
        end
    endfunction

endpackage

// File: rtl/ns_link_arbiter_rr_pick.sv
// Round-robin priority picker: lowest requesting index at or above ptr, else
// lowest requesting index overall (wrap). Purely combinational.
// Latency: 0 cycles. Backpressure: none, result follows inputs directly.
//
// Ports:
//   req   - one request bit per source
//   ptr   - first index with priority this round (must be < NSRC)
//   pick  - winning source index (0 when nothing requests)
//   found - high when at least one request bit is set
module ns_rr_pick
    import ns_link_arbiter_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    input  logic [RR_W-1:0] ptr,
    output logic [RR_W-1:0] pick,
    output logic            found
);

    logic [RR_W-1:0] hi_pick;
    logic            hi_found;
    logic [RR_W-1:0] lo_pick;
    logic            lo_found;

    // Scan from the top down so the last hit is the lowest index. The "hi"
    // search only counts indices at or above the pointer; if it comes up empty
    // the "lo" search supplies the wrapped-around winner.
    always_comb begin
        hi_pick  = '0;
        hi_found = 1'b0;
        lo_pick  = '0;
        lo_found = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_pick  = RR_W'(k);
                lo_found = 1'b1;
                if (RR_W'(k) >= ptr) begin
                    hi_pick  = RR_W'(k);
                    hi_found = 1'b1;
                end
            end
        end
        pick  = hi_found ? hi_pick : lo_pick;
        found = lo_found;
    end

endmodule

// File: rtl/ns_link_arbiter.sv
// Round-robin arbiter merging NSRC four-phase request/ack source channels onto
// one four-phase sink channel. Latency: o_req rises 1 cycle after IDLE sees a
// request. Backpressure: sink stalls by holding o_ack low; o_req/o_data hold.
//
// Ports:
//   i_clk, reset   - clock; asynchronous active-low reset
//   ready          - high from the first edge after reset release
//   i_data, i_req  - per-source data slices (k*DSZ +: DSZ) and requests
//   i_ack          - per-source acknowledge, only the grantee bit ever high
//   o_data, o_req  - registered message and request toward the sink
//   o_ack          - sink acknowledge
//   o_grant        - index of the current or most recent grantee
module ns_link_arbiter
    import ns_link_arbiter_pkg::*;
#(
    parameter int DSZ  = `NS_DATA_SIZE,
    parameter int NSRC = 4
) (
    input  logic                 i_clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic [NSRC*DSZ-1:0]  i_data,
    input  logic [NSRC-1:0]      i_req,
    output logic [NSRC-1:0]      i_ack,
    output logic [DSZ-1:0]       o_data,
    output logic                 o_req,
    input  logic                 o_ack,
    output logic [RR_W-1:0]      o_grant
);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [RR_W-1:0] rr_ptr;
    logic [RR_W-1:0] ptr_nxt;
    logic [RR_W-1:0] grant_nxt;
    logic [DSZ-1:0]  data_nxt;
    logic            req_nxt;
    logic [NSRC-1:0] ack_nxt;

    logic [RR_W-1:0] pick;
    logic            pick_vld;
    logic [DSZ-1:0]  pick_data;
    logic [NSRC-1:0] grant_mask;

    ns_rr_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .req   (i_req),
        .ptr   (rr_ptr),
        .pick  (pick),
        .found (pick_vld)
    );

    // Data slice of the round-robin winner; constant indices keep the mux
    // free of variable part-selects.
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (pick == RR_W'(k)) begin
                pick_data = i_data[k*DSZ +: DSZ];
            end
        end
    end

    // One-hot of the grantee. Both the ack drive and the req-drop test go
    // through this mask, so no other source's ack or req is ever looked at.
    assign grant_mask = {{(NSRC-1){1'b0}}, 1'b1} << o_grant;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = rr_ptr;
        grant_nxt = o_grant;
        data_nxt  = o_data;
        req_nxt   = o_req;
        ack_nxt   = i_ack;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    data_nxt  = pick_data;
                    grant_nxt = pick;
                    req_nxt   = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // A grantee dropping req early is ignored here: the message is
                // already latched and must reach the sink, so no abort path.
                if (o_ack) begin
                    ack_nxt   = grant_mask;
                    state_nxt = ST_ACKD;
                end
            end
            ST_ACKD: begin
                if ((i_req & grant_mask) == '0) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                // Pointer moves only when the transfer fully completes, so a
                // grantee re-requesting at once waits behind everyone else.
                if (!o_ack) begin
                    ack_nxt   = '0;
                    ptr_nxt   = rr_next(o_grant, NSRC);
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            o_req   <= 1'b0;
            i_ack   <= '0;
            o_data  <= '0;
            o_grant <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= ptr_nxt;
            o_req   <= req_nxt;
            i_ack   <= ack_nxt;
            o_data  <= data_nxt;
            o_grant <= grant_nxt;
            ready   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ns_link_arbiter.sv
// Bench for ns_link_arbiter: a 4-source build driven by directed transfers and
// a 2-source build driven by random-delay transfers. Source and sink models
// run on the falling edge; a monitor pops expected messages per grant.
module tb_ns_link_arbiter;
    import ns_link_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- DUT A: NSRC=4, DSZ=8 ----------------
    logic        rst_a = 1'b1;
    logic        ready_a;
    logic [31:0] i_data_a = '0;
    logic [3:0]  i_req_a = '0;
    logic [3:0]  i_ack_a;
    logic [7:0]  o_data_a;
    logic        o_req_a;
    logic        o_ack_a = 1'b0;
    logic [2:0]  o_grant_a;

    ns_link_arbiter #(.DSZ(8), .NSRC(4)) dut_a (
        .i_clk   (clk),
        .reset   (rst_a),
        .ready   (ready_a),
        .i_data  (i_data_a),
        .i_req   (i_req_a),
        .i_ack   (i_ack_a),
        .o_data  (o_data_a),
        .o_req   (o_req_a),
        .o_ack   (o_ack_a),
        .o_grant (o_grant_a)
    );

    // ---------------- DUT B: NSRC=2, DSZ=8 ----------------
    logic        rst_b = 1'b1;
    logic        ready_b;
    logic [15:0] i_data_b = '0;
    logic [1:0]  i_req_b = '0;
    logic [1:0]  i_ack_b;
    logic [7:0]  o_data_b;
    logic        o_req_b;
    logic        o_ack_b = 1'b0;
    logic [2:0]  o_grant_b;

    ns_link_arbiter #(.DSZ(8), .NSRC(2)) dut_b (
        .i_clk   (clk),
        .reset   (rst_b),
        .ready   (ready_b),
        .i_data  (i_data_b),
        .i_req   (i_req_b),
        .i_ack   (i_ack_b),
        .o_data  (o_data_b),
        .o_req   (o_req_b),
        .o_ack   (o_ack_b),
        .o_grant (o_grant_b)
    );

    // ---------------- A: source model ----------------
    logic [7:0]  a_msg [4][16];
    int          a_head [4] = '{0, 0, 0, 0};
    int          a_tail [4] = '{0, 0, 0, 0};
    int          a_ph   [4] = '{0, 0, 0, 0};
    logic        a_early[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        a_hold [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          a_sink_dly = 1;
    logic [10:0] exp_a[$];

    task automatic push_src(input int k, input logic [7:0] d);
        a_msg[k][a_tail[k]] = d;
        a_tail[k]++;
    endtask

    task automatic expect_a(input int k, input logic [7:0] d);
        exp_a.push_back({k[2:0], d});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                case (a_ph[k])
                    0: if (a_head[k] != a_tail[k]) begin
                        i_data_a[k*8 +: 8] = a_msg[k][a_head[k]];
                        i_req_a[k] = 1'b1;
                        a_ph[k] = 1;
                    end
                    1: if (a_early[k]) begin
                        i_req_a[k] = 1'b0;
                        a_ph[k] = 3;
                    end else if (i_ack_a[k] && !a_hold[k]) begin
                        i_req_a[k] = 1'b0;
                        a_ph[k] = 2;
                    end
                    3: if (i_ack_a[k]) a_ph[k] = 2;
                    2: if (!i_ack_a[k]) begin
                        a_head[k]++;
                        a_ph[k] = 0;
                    end
                    default: a_ph[k] = 0;
                endcase
            end
        end
    end

    // ---------------- A: sink + monitor ----------------
    initial begin : a_mon
        logic        a_seen;
        int          a_cnt;
        logic [10:0] got;
        a_seen = 1'b0;
        a_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                o_ack_a = 1'b0;
                a_seen  = 1'b0;
            end else begin
                check("a_ack_only_grantee", {28'd0, i_ack_a & ~(4'b0001 << o_grant_a)}, 32'd0);
                if (!a_seen && o_req_a) begin
                    if (exp_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected: got grant %0d data 0x%0h, expected no transfer",
                                 o_grant_a, o_data_a);
                    end else begin
                        got = exp_a.pop_front();
                        check("a_grant", {29'd0, o_grant_a}, {29'd0, got[10:8]});
                        check("a_data", {24'd0, o_data_a}, {24'd0, got[7:0]});
                    end
                    a_seen = 1'b1;
                    a_cnt  = a_sink_dly;
                    if (a_cnt == 0) o_ack_a = 1'b1;
                end else if (a_seen && !o_ack_a) begin
                    if (a_cnt > 0) a_cnt--;
                    if (a_cnt == 0) o_ack_a = 1'b1;
                end else if (a_seen && o_ack_a && !o_req_a) begin
                    o_ack_a = 1'b0;
                    a_seen  = 1'b0;
                end
            end
        end
    end

    function automatic bit a_quiet();
        bit q;
        q = (exp_a.size() == 0) && (dut_a.state == ST_IDLE) && (i_req_a == 4'b0) &&
            (i_ack_a == 4'b0) && !o_ack_a && !o_req_a;
        for (int k = 0; k < 4; k++) begin
            if (a_ph[k] != 0 || a_head[k] != a_tail[k]) q = 1'b0;
        end
        return q;
    endfunction

    task automatic wait_a_idle(input string name);
        int n;
        n = 0;
        while (!a_quiet() && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (!a_quiet()) begin
            errors++;
            $display("FAIL %s_done: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic wait_o_req_a(input string name);
        int n;
        n = 0;
        while (!o_req_a && n < 100) begin
            tick();
            n++;
        end
        check({name, "_o_req_rise"}, {31'd0, o_req_a}, 32'd1);
    endtask

    // ---------------- B: random source model ----------------
    localparam int B_PER_SRC = 500;
    int         b_sent[2] = '{0, 0};
    int         b_ph  [2] = '{0, 0};
    int         b_gap [2] = '{0, 0};
    logic [7:0] b_q0[$];
    logic [7:0] b_q1[$];
    int         b_deliv = 0;

    initial begin : b_src
        logic [7:0] d;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                case (b_ph[k])
                    0: if (rst_b && b_sent[k] < B_PER_SRC) begin
                        if (b_gap[k] > 0) begin
                            b_gap[k]--;
                        end else begin
                            d = {k[0], b_sent[k][6:0]};
                            i_data_b[k*8 +: 8] = d;
                            if (k == 0) b_q0.push_back(d);
                            else        b_q1.push_back(d);
                            i_req_b[k] = 1'b1;
                            b_ph[k] = 1;
                        end
                    end
                    1: if (i_ack_b[k]) begin
                        i_req_b[k] = 1'b0;
                        b_ph[k] = 2;
                    end
                    2: if (!i_ack_b[k]) begin
                        b_sent[k]++;
                        b_gap[k] = int'($urandom_range(0, 3));
                        b_ph[k] = 0;
                    end
                    default: b_ph[k] = 0;
                endcase
            end
        end
    end

    // ---------------- B: random sink + monitor ----------------
    initial begin : b_mon
        logic       b_seen;
        int         b_cnt;
        logic [7:0] bexp;
        b_seen = 1'b0;
        b_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                o_ack_b = 1'b0;
                b_seen  = 1'b0;
            end else begin
                check("b_ack_only_grantee", {30'd0, i_ack_b & ~(2'b01 << o_grant_b)}, 32'd0);
                if (!b_seen && o_req_b) begin
                    if (o_grant_b == 3'd0 && b_q0.size() > 0) begin
                        bexp = b_q0.pop_front();
                        check("b_data_src0", {24'd0, o_data_b}, {24'd0, bexp});
                    end else if (o_grant_b == 3'd1 && b_q1.size() > 0) begin
                        bexp = b_q1.pop_front();
                        check("b_data_src1", {24'd0, o_data_b}, {24'd0, bexp});
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: got grant %0d data 0x%0h, expected a pending source",
                                 o_grant_b, o_data_b);
                    end
                    b_deliv++;
                    b_seen = 1'b1;
                    b_cnt  = int'($urandom_range(0, 3));
                    if (b_cnt == 0) o_ack_b = 1'b1;
                end else if (b_seen && !o_ack_b) begin
                    if (b_cnt > 0) b_cnt--;
                    if (b_cnt == 0) o_ack_b = 1'b1;
                end else if (b_seen && o_ack_b && !o_req_b) begin
                    o_ack_b = 1'b0;
                    b_seen  = 1'b0;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int n;
        int c0;
        int c1;

        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_o_req", {31'd0, o_req_a}, 32'd0);
        check("rst_i_ack", {28'd0, i_ack_a}, 32'd0);
        check("rst_o_data", {24'd0, o_data_a}, 32'd0);
        check("rst_o_grant", {29'd0, o_grant_a}, 32'd0);
        check("rst_state", {30'd0, dut_a.state}, {30'd0, ST_IDLE});

        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("rel_ready_before_edge", {31'd0, ready_a}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_ready_after_edge", {31'd0, ready_a}, 32'd1);
        check("rel_ready_b", {31'd0, ready_b}, 32'd1);

        // All four sources at once from reset: 0,1,2,3 then wrap to 0
        push_src(0, 8'h11); push_src(1, 8'h22); push_src(2, 8'h33);
        push_src(3, 8'h44); push_src(0, 8'h55);
        expect_a(0, 8'h11); expect_a(1, 8'h22); expect_a(2, 8'h33);
        expect_a(3, 8'h44); expect_a(0, 8'h55);
        wait_a_idle("rr_all4");

        // Sources 1 and 3; source 1 re-requests at once -> 1, 3, 1
        push_src(1, 8'h61); push_src(3, 8'h63); push_src(1, 8'h62);
        expect_a(1, 8'h61); expect_a(3, 8'h63); expect_a(1, 8'h62);
        wait_a_idle("rr_rerequest");

        // Single source 2, o_req one cycle after the request is seen
        push_src(2, 8'h05);
        expect_a(2, 8'h05);
        n = 0;
        while (!i_req_a[2] && n < 20) begin
            tick();
            n++;
        end
        c0 = cyc;
        n = 0;
        while (!o_req_a && n < 20) begin
            tick();
            n++;
        end
        c1 = cyc;
        check("single_latency", c1 - c0, 32'd1);
        check("single_grant", {29'd0, o_grant_a}, 32'd2);
        wait_a_idle("single");

        // Slow sink: 20 cycles without ack
        a_sink_dly = 20;
        push_src(0, 8'h3C);
        expect_a(0, 8'h3C);
        wait_o_req_a("stall");
        repeat (15) tick();
        check("stall_o_req", {31'd0, o_req_a}, 32'd1);
        check("stall_o_data", {24'd0, o_data_a}, 32'h3C);
        check("stall_state", {30'd0, dut_a.state}, {30'd0, ST_SEND});
        check("stall_i_ack", {28'd0, i_ack_a}, 32'd0);
        wait_a_idle("stall");

        // Grantee drops req before ack: o_req must stay up in SEND
        a_sink_dly = 6;
        a_early[1] = 1'b1;
        push_src(1, 8'hA5);
        expect_a(1, 8'hA5);
        wait_o_req_a("early");
        repeat (3) tick();
        check("early_o_req", {31'd0, o_req_a}, 32'd1);
        check("early_state", {30'd0, dut_a.state}, {30'd0, ST_SEND});
        check("early_o_data", {24'd0, o_data_a}, 32'hA5);
        wait_a_idle("early");
        a_early[1] = 1'b0;
        a_sink_dly = 1;

        // Reset while in ACKD, then re-arbitration from source 0
        a_hold[2] = 1'b1;
        push_src(2, 8'h77);
        expect_a(2, 8'h77);
        n = 0;
        while (dut_a.state != ST_ACKD && n < 100) begin
            tick();
            n++;
        end
        check("ackd_reached", {30'd0, dut_a.state}, {30'd0, ST_ACKD});
        rst_a = 1'b0;
        #1;
        check("mid_rst_o_req", {31'd0, o_req_a}, 32'd0);
        check("mid_rst_i_ack", {28'd0, i_ack_a}, 32'd0);
        check("mid_rst_ready", {31'd0, ready_a}, 32'd0);
        check("mid_rst_state", {30'd0, dut_a.state}, {30'd0, ST_IDLE});
        push_src(0, 8'h10);
        expect_a(0, 8'h10);
        expect_a(2, 8'h77);
        a_hold[2] = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("mid_rel_ready_before_edge", {31'd0, ready_a}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rel_ready_after_edge", {31'd0, ready_a}, 32'd1);
        wait_a_idle("mid_reset");

        // Random 2-source build: wait for all transfers to finish
        n = 0;
        while ((b_sent[0] < B_PER_SRC || b_sent[1] < B_PER_SRC) && n < 40000) begin
            tick();
            n++;
        end
        check("b_src0_done", b_sent[0], B_PER_SRC);
        check("b_src1_done", b_sent[1], B_PER_SRC);
        check("b_delivered", b_deliv, 2 * B_PER_SRC);
        check("b_q0_left", b_q0.size(), 32'd0);
        check("b_q1_left", b_q1.size(), 32'd0);
        check("a_exp_left", exp_a.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ns_link_arbiter.md
NS_LINK_ARBITER -- requirements
Module: ns_link_arbiter

Interface
REQ-001 Parameter DSZ, default `NS_DATA_SIZE; width of every message data bus.
REQ-002 Parameter NSRC, default 4; number of source channels, legal 2..8.
REQ-003 Port i_clk  input  1  single clock; all state updates on posedge i_clk.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port ready  output  1  high when the arbiter has left reset and is operational.
REQ-006 Port i_data  input  NSRC*DSZ  source data; slice k = bits [k*DSZ +: DSZ].
REQ-007 Port i_req  input  NSRC  per-source request, four-phase level handshake.
REQ-008 Port i_ack  output  NSRC  per-source acknowledge, registered.
REQ-009 Port o_data  output  DSZ  forwarded message data, registered.
REQ-010 Port o_req  output  1  request toward the shared sink channel, registered.
REQ-011 Port o_ack  input  1  acknowledge from the shared sink channel.
REQ-012 Port o_grant  output  3  index of the current or last granted source.

Function
REQ-013 Four-phase protocol on every channel: req rises with data stable, ack rises, req falls, ack falls; data stays valid from req rise until ack rises.
REQ-014 FSM states: IDLE, SEND, ACKD, DROP.
REQ-015 IDLE: if any i_req bit is high, select a winner round-robin starting at pointer rr_ptr (lowest index at or above rr_ptr, wrapping to 0).
- On the next edge: latch o_data = winner slice, set o_grant = winner, o_req = 1, go to SEND.
REQ-016 SEND: hold o_req = 1 and o_data stable; when o_ack = 1, set i_ack[o_grant] = 1 on the next edge and go to ACKD.
REQ-017 ACKD: when i_req[o_grant] = 0, set o_req = 0 on the next edge and go to DROP.
REQ-018 DROP: when o_ack = 0, set i_ack[o_grant] = 0 on the next edge, set rr_ptr = (o_grant+1) mod NSRC, and go to IDLE.
REQ-019 Only i_ack[o_grant] may be high; every other i_ack bit stays 0 at all times.
REQ-020 Latency: o_req rises 1 cycle after the first IDLE cycle that sees a request; a new grant is possible 1 cycle after return to IDLE, so the minimum transfer is 5 cycles plus the sink's response cycles.
REQ-021 Requests from sources other than the grantee are ignored until IDLE; they are never lost and are not required to drop.
REQ-022 Simultaneous requests are served in strict round-robin order; with all NSRC sources requesting continuously, each is granted exactly once per NSRC transfers.
REQ-023 A grantee that drops i_req before o_ack rises is a protocol violation; the arbiter keeps o_req high and stays in SEND (no abort).
REQ-024 rr_ptr wraps from NSRC-1 to 0.

Reset
REQ-025 While reset = 0, asynchronously: state = IDLE, rr_ptr = 0, o_req = 0, i_ack = 0, o_data = 0, o_grant = 0, ready = 0.
REQ-026 ready rises on the first posedge after reset deasserts and stays high.
REQ-027 Reset asserted mid-transfer aborts it immediately (o_req and i_ack drop); after release, pending requests are re-arbitrated from index 0.

Structure
REQ-028 FSM state encodings and the round-robin width constant live in the shared hglobal.v package; DSZ defaults come from `NS_DATA_SIZE.
REQ-029 One sub-module: ns_rr_pick (combinational round-robin priority picker: NSRC-bit request vector plus pointer in, winner index and valid out); all registers live in ns_link_arbiter.

Verification
REQ-030 Single source: i_req[2] = 1, i_data slice2 = 0x5 -> o_req = 1 one cycle later with o_data = 0x5, o_grant = 2; full handshake completes with i_ack[2] only.
REQ-031 All four sources request at once from reset -> grants are issued in order 0,1,2,3,0; rr_ptr wraps.
REQ-032 Sources 1 and 3 request, source 1 is served, then source 1 re-requests immediately -> source 3 is granted before source 1.
REQ-033 Sink holds o_ack = 0 for 20 cycles -> o_req and o_data stay stable, FSM remains in SEND, i_ack remains 0.
REQ-034 Reset pulsed low while in ACKD -> o_req = 0 and i_ack = 0 asynchronously; ready = 0 until the first edge after release, then pending requests restart from source 0.
REQ-035 NSRC = 2, DSZ = 8 build, 1000 random-delay four-phase transfers -> every message is delivered exactly once, in order per source, with no protocol violation.
